// File: rtl/axi_slv_wresp_model.sv
// ============================================================================
// axi_slv_wresp_model
// ----------------------------------------------------------------------------
// Behavioural AXI slave write-side responder used on a crossbar slave port.
// AW requests are queued; W beats are consumed (optionally with LFSR-gated
// wready) and checked against the AW at the queue head for beat count, wlast
// placement and wid. One B response per burst is issued after a programmable
// number of idle cycles.
//
// Optional feature macro: AXI_SLV_WCHK_EN
//   defined     : out_wchk accumulates a strobe-masked XOR of accepted wdata
//   not defined : out_wchk is tied to zero, no checksum register exists
//
// Parameters
//   AXI_ADDR_W      address width
//   AXI_ID_W        ID width
//   AXI_DATA_W      data width (wstrb is fixed at 4 bits)
//   SLV_OSTDREQ_NUM AW / B queue depth, power of two, >= 2
//   B_LATENCY       idle cycles before each bvalid, 0..15
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   in_awvalid/out_awready        AW handshake; in_awaddr/in_awlen/in_awid
//   in_wvalid/out_wready          W handshake; in_wlast/in_wid/in_wdata/in_wstrb
//   out_bvalid/in_bready          B handshake; out_bid/out_bresp payload
//   ready_rand                    1: wready additionally gated by LFSR bit 0
//   out_err_wlast, out_err_wid    sticky protocol-check flags
//   out_wchk                      running data checksum (see macro above)
// ============================================================================
module axi_slv_wresp_model #(
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int SLV_OSTDREQ_NUM = 4,
    parameter int B_LATENCY       = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  in_awvalid,
    output logic                  out_awready,
    input  logic [AXI_ADDR_W-1:0] in_awaddr,
    input  logic [7:0]            in_awlen,
    input  logic [AXI_ID_W-1:0]   in_awid,
    input  logic                  in_wvalid,
    output logic                  out_wready,
    input  logic                  in_wlast,
    input  logic [AXI_ID_W-1:0]   in_wid,
    input  logic [AXI_DATA_W-1:0] in_wdata,
    input  logic [3:0]            in_wstrb,
    output logic                  out_bvalid,
    input  logic                  in_bready,
    output logic [AXI_ID_W-1:0]   out_bid,
    output logic [1:0]            out_bresp,
    input  logic                  ready_rand,
    output logic                  out_err_wlast,
    output logic                  out_err_wid,
    output logic [AXI_DATA_W-1:0] out_wchk
);

    localparam int          IDX_W     = $clog2(SLV_OSTDREQ_NUM);
    localparam int          PTR_W     = IDX_W + 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [3:0]  B_LAT     = 4'(B_LATENCY);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLVE = 2'b10;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AXI_ADDR_W-1:0] r_aw_addr [SLV_OSTDREQ_NUM];
    logic [7:0]            r_aw_len  [SLV_OSTDREQ_NUM];
    logic [AXI_ID_W-1:0]   r_aw_id   [SLV_OSTDREQ_NUM];
    logic [PTR_W-1:0]      r_aw_wptr;
    logic [PTR_W-1:0]      r_aw_rptr;

    logic [AXI_ID_W-1:0]   r_b_id    [SLV_OSTDREQ_NUM];
    logic [1:0]            r_b_resp  [SLV_OSTDREQ_NUM];
    logic [PTR_W-1:0]      r_b_wptr;
    logic [PTR_W-1:0]      r_b_rptr;
    logic [3:0]            r_dly_cnt;

    logic [15:0]           r_lfsr;
    logic [7:0]            r_beat_cnt;
    logic                  r_bad;
    logic                  r_err_wlast;
    logic                  r_err_wid;

    // ------------------------------------------------------------------------
    // Queue status and handshake decode (all from registered state)
    // ------------------------------------------------------------------------
    logic                  w_aw_empty;
    logic                  w_aw_full;
    logic                  w_b_empty;
    logic                  w_b_full;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic                  w_aw_push;
    logic                  w_w_hs;
    logic                  w_b_pop;
    logic [7:0]            w_head_len;
    logic [AXI_ID_W-1:0]   w_head_id;
    logic                  w_exp_last;
    logic                  w_beat_err_wlast;
    logic                  w_beat_err_wid;
    logic                  w_burst_done;
    logic [1:0]            w_new_resp;
    logic [AXI_ID_W-1:0]   w_b_head_id;
    logic [1:0]            w_b_head_resp;
    logic                  w_lfsr_fb;
    logic                  w_unused_sink;

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign w_aw_empty = (r_aw_wptr == r_aw_rptr);
    assign w_aw_full  = (r_aw_wptr[IDX_W-1:0] == r_aw_rptr[IDX_W-1:0]) &&
                        (r_aw_wptr[IDX_W] != r_aw_rptr[IDX_W]);
    assign w_b_empty  = (r_b_wptr == r_b_rptr);
    assign w_b_full   = (r_b_wptr[IDX_W-1:0] == r_b_rptr[IDX_W-1:0]) &&
                        (r_b_wptr[IDX_W] != r_b_rptr[IDX_W]);

    // awready looks only at the registered full flag, so a same-cycle pop
    // never opens the queue early.
    assign w_awready = !w_aw_full;
    // wready requires room for the B entry the burst will eventually produce.
    assign w_wready  = !w_aw_empty && !w_b_full && (!ready_rand || r_lfsr[0]);
    assign w_bvalid  = !w_b_empty && (r_dly_cnt == B_LAT);

    assign w_aw_push = in_awvalid && w_awready;
    assign w_w_hs    = in_wvalid && w_wready;
    assign w_b_pop   = w_bvalid && in_bready;

    assign w_head_len    = r_aw_len[r_aw_rptr[IDX_W-1:0]];
    assign w_head_id     = r_aw_id[r_aw_rptr[IDX_W-1:0]];
    assign w_b_head_id   = r_b_id[r_b_rptr[IDX_W-1:0]];
    assign w_b_head_resp = r_b_resp[r_b_rptr[IDX_W-1:0]];

    // The burst boundary comes from the counted length; wlast is only checked.
    assign w_exp_last       = (r_beat_cnt == w_head_len);
    assign w_beat_err_wlast = w_w_hs && (in_wlast != w_exp_last);
    assign w_beat_err_wid   = w_w_hs && (in_wid != w_head_id);
    assign w_burst_done     = w_w_hs && w_exp_last;
    // The final beat's own errors must be reflected in the response.
    assign w_new_resp       = (r_bad || w_beat_err_wlast || w_beat_err_wid) ?
                              RESP_SLVE : RESP_OKAY;

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // The stored address is carried for completeness but not otherwise used.
    assign w_unused_sink = ^{r_aw_addr[r_aw_rptr[IDX_W-1:0]], in_wdata, in_wstrb};

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // AW queue storage and pointers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_wptr <= {PTR_W{1'b0}};
            r_aw_rptr <= {PTR_W{1'b0}};
            for (int i = 0; i < SLV_OSTDREQ_NUM; i++) begin
                r_aw_addr[i] <= {AXI_ADDR_W{1'b0}};
                r_aw_len[i]  <= 8'h00;
                r_aw_id[i]   <= {AXI_ID_W{1'b0}};
            end
        end else begin
            if (w_aw_push) begin
                r_aw_addr[r_aw_wptr[IDX_W-1:0]] <= in_awaddr;
                r_aw_len[r_aw_wptr[IDX_W-1:0]]  <= in_awlen;
                r_aw_id[r_aw_wptr[IDX_W-1:0]]   <= in_awid;
                r_aw_wptr <= r_aw_wptr + PTR_W'(1);
            end
            if (w_burst_done) begin
                r_aw_rptr <= r_aw_rptr + PTR_W'(1);
            end
        end
    end

    // Beat counter, per-burst bad flag and sticky error flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt  <= 8'h00;
            r_bad       <= 1'b0;
            r_err_wlast <= 1'b0;
            r_err_wid   <= 1'b0;
        end else begin
            if (w_w_hs) begin
                if (w_exp_last) begin
                    r_beat_cnt <= 8'h00;
                    r_bad      <= 1'b0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                    r_bad      <= r_bad | w_beat_err_wlast | w_beat_err_wid;
                end
            end
            if (w_beat_err_wlast) begin
                r_err_wlast <= 1'b1;
            end
            if (w_beat_err_wid) begin
                r_err_wid <= 1'b1;
            end
        end
    end

    // B queue storage and pointers; push and pop may coincide.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_b_wptr <= {PTR_W{1'b0}};
            r_b_rptr <= {PTR_W{1'b0}};
            for (int i = 0; i < SLV_OSTDREQ_NUM; i++) begin
                r_b_id[i]   <= {AXI_ID_W{1'b0}};
                r_b_resp[i] <= 2'b00;
            end
        end else begin
            if (w_burst_done) begin
                r_b_id[r_b_wptr[IDX_W-1:0]]   <= w_head_id;
                r_b_resp[r_b_wptr[IDX_W-1:0]] <= w_new_resp;
                r_b_wptr <= r_b_wptr + PTR_W'(1);
            end
            if (w_b_pop) begin
                r_b_rptr <= r_b_rptr + PTR_W'(1);
            end
        end
    end

    // Response delay: counts idle cycles for the current head, restarts on pop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dly_cnt <= 4'h0;
        end else if (w_b_pop) begin
            r_dly_cnt <= 4'h0;
        end else if (!w_b_empty && !w_bvalid) begin
            r_dly_cnt <= r_dly_cnt + 4'd1;
        end else begin
            r_dly_cnt <= r_dly_cnt;
        end
    end

    // Free-running LFSR for randomised wready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

`ifdef AXI_SLV_WCHK_EN
    logic [AXI_DATA_W-1:0] r_wchk;

    // Expand each strobe bit over its byte lane; lanes beyond wstrb are masked.
    function automatic logic [AXI_DATA_W-1:0] strb_mask(input logic [3:0] strb);
        logic [AXI_DATA_W-1:0] m;
        m = {AXI_DATA_W{1'b0}};
        for (int b = 0; b < AXI_DATA_W / 8; b++) begin
            m[b*8 +: 8] = (b < 4) ? {8{strb[b[1:0]]}} : 8'h00;
        end
        return m;
    endfunction

    // Running checksum of accepted write data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wchk <= {AXI_DATA_W{1'b0}};
        end else if (w_w_hs) begin
            r_wchk <= r_wchk ^ (in_wdata & strb_mask(in_wstrb));
        end else begin
            r_wchk <= r_wchk;
        end
    end

    assign out_wchk = r_wchk;
`else
    assign out_wchk = {AXI_DATA_W{1'b0}};
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_awready   = w_awready;
    assign out_wready    = w_wready;
    assign out_bvalid    = w_bvalid;
    // Payload is forced to zero while no response is offered, so it reads 0
    // out of reset; it is the stable queue head while bvalid is high.
    assign out_bid       = w_bvalid ? w_b_head_id : {AXI_ID_W{1'b0}};
    assign out_bresp     = w_bvalid ? w_b_head_resp : 2'b00;
    assign out_err_wlast = r_err_wlast;
    assign out_err_wid   = r_err_wid;

endmodule

// File: tb/tb_axi_slv_wresp_model.sv
module tb_axi_slv_wresp_model;

    localparam int ALL_BEATS = 1000;
`ifdef AXI_SLV_WCHK_EN
    localparam logic [31:0] WCHK_EXP = 32'hFFFF0078;
`else
    localparam logic [31:0] WCHK_EXP = 32'h0000_0000;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_awvalid = 1'b0;
    logic        out_awready;
    logic [31:0] in_awaddr = 32'h0;
    logic [7:0]  in_awlen = 8'h0;
    logic [3:0]  in_awid = 4'h0;
    logic        in_wvalid = 1'b0;
    logic        out_wready;
    logic        in_wlast = 1'b0;
    logic [3:0]  in_wid = 4'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [3:0]  in_wstrb = 4'h0;
    logic        out_bvalid;
    logic        in_bready = 1'b0;
    logic [3:0]  out_bid;
    logic [1:0]  out_bresp;
    logic        ready_rand = 1'b0;
    logic        out_err_wlast;
    logic        out_err_wid;
    logic [31:0] out_wchk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference state
    logic [5:0]  m_bq[$];
    logic        m_err_wlast;
    logic        m_err_wid;
    logic [31:0] m_wchk;
    logic [31:0] beat_data [256];
    logic [3:0]  beat_strb [256];

    axi_slv_wresp_model #(
        .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32),
        .SLV_OSTDREQ_NUM(4), .B_LATENCY(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_awvalid(in_awvalid), .out_awready(out_awready),
        .in_awaddr(in_awaddr), .in_awlen(in_awlen), .in_awid(in_awid),
        .in_wvalid(in_wvalid), .out_wready(out_wready), .in_wlast(in_wlast),
        .in_wid(in_wid), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
        .out_bvalid(out_bvalid), .in_bready(in_bready),
        .out_bid(out_bid), .out_bresp(out_bresp),
        .ready_rand(ready_rand),
        .out_err_wlast(out_err_wlast), .out_err_wid(out_err_wid),
        .out_wchk(out_wchk)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) m = m | (32'h0000_00FF << (8 * i));
        end
        return m;
    endfunction

    task automatic model_clear();
        m_bq.delete();
        m_err_wlast = 1'b0;
        m_err_wid   = 1'b0;
        m_wchk      = 32'h0;
    endtask

    task automatic apply_reset();
        in_awvalid = 1'b0; in_wvalid = 1'b0; in_wlast = 1'b0; in_bready = 1'b0;
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        model_clear();
    endtask

    task automatic fill_rand(input int len);
        for (int b = 0; b <= len; b++) begin
            beat_data[b] = $urandom;
            beat_strb[b] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic push_aw(input logic [3:0] id, input logic [7:0] len);
        int w;
        w = 0;
        in_awvalid = 1'b1; in_awid = id; in_awlen = len; in_awaddr = $urandom;
        while (!out_awready && w < 50) begin tick(); w++; end
        if (!out_awready) chk("aw_wait", 32'(out_awready), 32'd1);
        else tick();
        in_awvalid = 1'b0;
    endtask

    // Sends len+1 beats; wl_err flips wlast on that beat, wid_err corrupts
    // wid on that beat (ALL_BEATS: every beat).
    task automatic send_w_burst(input logic [3:0] id, input logic [7:0] len,
                                input int wl_err, input int wid_err);
        int  w;
        bit  bad;
        bit  idbad;
        bad = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            idbad     = (b == wid_err) || (wid_err == ALL_BEATS);
            in_wvalid = 1'b1;
            in_wid    = idbad ? (id ^ 4'h3) : id;
            in_wlast  = (b == int'(len)) ^ (b == wl_err);
            in_wdata  = beat_data[b];
            in_wstrb  = beat_strb[b];
            w = 0;
            while (!out_wready && w < 200) begin tick(); w++; end
            if (!out_wready) begin
                chk("w_wait", 32'(out_wready), 32'd1);
                in_wvalid = 1'b0;
                return;
            end
            tick();
            if (idbad) begin m_err_wid = 1'b1; bad = 1'b1; end
            if (b == wl_err) begin m_err_wlast = 1'b1; bad = 1'b1; end
`ifdef AXI_SLV_WCHK_EN
            m_wchk = m_wchk ^ (beat_data[b] & byte_mask(beat_strb[b]));
`endif
        end
        in_wvalid = 1'b0;
        in_wlast  = 1'b0;
        m_bq.push_back({id, bad ? 2'b10 : 2'b00});
    endtask

    // Collects n responses in order, stalling bready and checking stability.
    task automatic collect_b(input int n, input bit long_hold);
        int         w;
        int         stall;
        logic [5:0] e;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!out_bvalid && w < 60) begin tick(); w++; end
            chk("b_wait", 32'(out_bvalid), 32'd1);
            if (!out_bvalid) return;
            if (m_bq.size() == 0) begin
                chk("b_extra", 32'(out_bvalid), 32'd0);
                return;
            end
            e = m_bq.pop_front();
            chk("b_id", 32'(out_bid), 32'(e[5:2]));
            chk("b_resp", 32'(out_bresp), 32'(e[1:0]));
            stall = long_hold ? 10 : int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("b_hold_valid", 32'(out_bvalid), 32'd1);
                chk("b_hold_id", 32'(out_bid), 32'(e[5:2]));
                chk("b_hold_resp", 32'(out_bresp), 32'(e[1:0]));
            end
            in_bready = 1'b1;
            tick();
            in_bready = 1'b0;
            chk("b_fresh_latency", 32'(out_bvalid), 32'd0);
        end
    endtask

    initial begin
        int          w;
        int          k;
        logic [3:0]  ids  [4];
        logic [7:0]  lens [4];
        int          wl;
        int          wi;

        model_clear();

        // ---- reset values ----
        tick(); tick();
        aresetn = 1'b1;
        chk("rst_awready", 32'(out_awready), 32'd1);
        chk("rst_wready", 32'(out_wready), 32'd0);
        chk("rst_bvalid", 32'(out_bvalid), 32'd0);
        chk("rst_bid", 32'(out_bid), 32'd0);
        chk("rst_bresp", 32'(out_bresp), 32'd0);
        chk("rst_err_wlast", 32'(out_err_wlast), 32'd0);
        chk("rst_err_wid", 32'(out_err_wid), 32'd0);
        chk("rst_wchk", out_wchk, 32'd0);

        // ---- single burst, exact timing ----
        ready_rand = 1'b0;
        in_bready  = 1'b1;
        in_awvalid = 1'b1; in_awlen = 8'd3; in_awid = 4'h5; in_awaddr = 32'h1000;
        tick();
        in_awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_wvalid = 1'b1; in_wid = 4'h5; in_wlast = (b == 3);
            in_wdata = $urandom; in_wstrb = 4'hF;
            chk("sb_wready", 32'(out_wready), 32'd1);
            tick();
        end
        in_wvalid = 1'b0; in_wlast = 1'b0;
        chk("sb_wready_after", 32'(out_wready), 32'd0);
        chk("sb_bvalid_T", 32'(out_bvalid), 32'd0);
        tick();
        chk("sb_bvalid_T1", 32'(out_bvalid), 32'd0);
        tick();
        chk("sb_bvalid_T2", 32'(out_bvalid), 32'd1);
        chk("sb_bid", 32'(out_bid), 32'h5);
        chk("sb_bresp", 32'(out_bresp), 32'd0);
        tick();
        chk("sb_bvalid_pop", 32'(out_bvalid), 32'd0);
        chk("sb_err_wlast", 32'(out_err_wlast), 32'd0);
        chk("sb_err_wid", 32'(out_err_wid), 32'd0);

        // ---- fill AW queue, B backpressure ----
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_awvalid = 1'b1; in_awlen = 8'd1; in_awid = 4'(i + 1);
            chk("fill_awready", 32'(out_awready), 32'd1);
            tick();
        end
        in_awvalid = 1'b1; in_awid = 4'h5; in_awlen = 8'd1;
        chk("fill_awready_full", 32'(out_awready), 32'd0);
        fill_rand(1);
        send_w_burst(4'h1, 8'd1, -1, -1);
        chk("fill_awready_reopen", 32'(out_awready), 32'd1);
        tick();
        in_awvalid = 1'b0;
        chk("fill_awready_refull", 32'(out_awready), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            fill_rand(1);
            send_w_burst(4'(i), 8'd1, -1, -1);
        end
        chk("bfull_wready", 32'(out_wready), 32'd0);
        collect_b(1, 1'b1);
        chk("bfull_wready_free", 32'(out_wready), 32'd1);
        fill_rand(1);
        send_w_burst(4'h5, 8'd1, -1, -1);
        collect_b(4, 1'b0);

        // ---- early wlast ----
        apply_reset();
        push_aw(4'h5, 8'd3);
        fill_rand(3);
        send_w_burst(4'h5, 8'd3, 1, -1);
        chk("ewl_wready_done", 32'(out_wready), 32'd0);
        chk("ewl_err_wlast", 32'(out_err_wlast), 32'd1);
        chk("ewl_err_wid", 32'(out_err_wid), 32'd0);
        collect_b(1, 1'b0);

        // ---- wrong wid ----
        apply_reset();
        chk("wid_rst_err_wlast", 32'(out_err_wlast), 32'd0);
        push_aw(4'h5, 8'd3);
        fill_rand(3);
        send_w_burst(4'h5, 8'd3, -1, ALL_BEATS);
        chk("wid_err_wid", 32'(out_err_wid), 32'd1);
        chk("wid_err_wlast", 32'(out_err_wlast), 32'd0);
        collect_b(1, 1'b0);

        // ---- reset asserted mid-burst with a response pending ----
        apply_reset();
        push_aw(4'h7, 8'd0);
        fill_rand(0);
        send_w_burst(4'h7, 8'd0, -1, -1);
        w = 0;
        while (!out_bvalid && w < 20) begin tick(); w++; end
        chk("mid_pre_bvalid", 32'(out_bvalid), 32'd1);
        push_aw(4'h8, 8'd3);
        in_wvalid = 1'b1; in_wid = 4'h8; in_wlast = 1'b0; in_wstrb = 4'hF;
        tick();
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_bvalid_async", 32'(out_bvalid), 32'd0);
        chk("mid_bid_async", 32'(out_bid), 32'd0);
        chk("mid_wready", 32'(out_wready), 32'd0);
        chk("mid_awready", 32'(out_awready), 32'd1);
        in_wvalid = 1'b0;
        model_clear();
        tick();
        aresetn = 1'b1;
        push_aw(4'h9, 8'd1);
        fill_rand(1);
        send_w_burst(4'h9, 8'd1, -1, -1);
        collect_b(1, 1'b0);

        // ---- write checksum ----
        apply_reset();
        push_aw(4'h2, 8'd1);
        beat_data[0] = 32'hFFFF0000; beat_strb[0] = 4'hF;
        beat_data[1] = 32'h12345678; beat_strb[1] = 4'h1;
        send_w_burst(4'h2, 8'd1, -1, -1);
        chk("wchk_const", out_wchk, WCHK_EXP);
        collect_b(1, 1'b0);

        // ---- randomized rounds with LFSR-gated wready ----
        apply_reset();
        ready_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(1, 4));
            for (int j = 0; j < k; j++) begin
                ids[j]  = 4'($urandom_range(0, 15));
                lens[j] = 8'($urandom_range(0, 7));
                chk("rnd_awready", 32'(out_awready), 32'd1);
                push_aw(ids[j], lens[j]);
            end
            for (int j = 0; j < k; j++) begin
                fill_rand(int'(lens[j]));
                wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(lens[j]))) : -1;
                wi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(lens[j]))) : -1;
                send_w_burst(ids[j], lens[j], wl, wi);
            end
            collect_b(k, 1'b0);
            chk("rnd_err_wlast", 32'(out_err_wlast), 32'(m_err_wlast));
            chk("rnd_err_wid", 32'(out_err_wid), 32'(m_err_wid));
            chk("rnd_wchk", out_wchk, m_wchk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
